add_sub_accumulator: RTL and testbench

- Parametrised, registered two's-complement add/subtract unit with an internal accumulator, optional signed saturation and a full flag set (carry, overflow, zero, negative, sticky overflow).
- Uses a valid/ready handshake on input and output with a single output register stage.
- Is the sequential successor to the 4-bit combinational adder/subtracter.
- Sits between operand sources and the datapath result bus.

---
 rtl/add_sub_accumulator.sv | 134 +++++++++++++
 tb/tb_add_sub_accumulator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_accumulator.sv
// add_sub_accumulator: registered two's-complement add/subtract unit with an
// internal accumulator, optional signed saturation and a full flag set.
// A valid/ready handshake surrounds a single output register stage. The
// register is one deep and can be refilled in the same cycle it is drained.
module add_sub_accumulator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             sat,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c,
   output logic             v,
   output logic             z,
   output logic             n,
   output logic             v_sticky
);

   localparam int MSB = WIDTH - 1;

   // Clamp to the signed extreme on the side of x when the result overflowed.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                 input logic             ovf,
                                                 input logic             en,
                                                 input logic             x_msb);
      logic [WIDTH-1:0] res;
      res = raw;
      if (en && ovf) begin
         res = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
      return res;
   endfunction

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             out_valid_q, out_valid_d;
   logic             v_sticky_q, v_sticky_d;

   logic             accept;
   logic [WIDTH-1:0] acc_opnd;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_eff;
   logic [WIDTH:0]   raw;
   logic             ovf;
   logic [WIDTH-1:0] final_sum;
   logic             sticky_base;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Operand selection, add/subtract, overflow detection and saturation.
   always_comb begin
      // A clear in the same cycle makes an accumulator op start from zero.
      acc_opnd  = clr ? '0 : acc_q;
      x         = op[1] ? acc_opnd : a;
      y         = op[1] ? a : b;
      y_eff     = op[0] ? ~y : y;
      raw       = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, op[0]};
      ovf       = (x[MSB] == y_eff[MSB]) && (raw[MSB] != x[MSB]);
      final_sum = saturate(raw[WIDTH-1:0], ovf, sat, x[MSB]);
   end

   // Next-state for result register, accumulator, sticky flag and valid.
   always_comb begin
      sum_d       = sum_q;
      c_d         = c_q;
      v_d         = v_q;
      z_d         = z_q;
      n_d         = n_q;
      // Clear drops the stale accumulator and sticky flag; an accepted beat
      // still contributes its own result on top of that.
      acc_d       = clr ? '0 : acc_q;
      sticky_base = clr ? 1'b0 : v_sticky_q;
      v_sticky_d  = sticky_base;
      out_valid_d = out_ready ? 1'b0 : out_valid_q;
      if (accept) begin
         sum_d       = final_sum;
         c_d         = raw[WIDTH];
         v_d         = ovf;
         z_d         = (final_sum == '0);
         n_d         = final_sum[MSB];
         v_sticky_d  = sticky_base | ovf;
         out_valid_d = 1'b1;
         if (op[1]) begin
            acc_d = final_sum;
         end
      end
   end

   // State registers; reset discards any held result and the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         sum_q       <= '0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         out_valid_q <= 1'b0;
         v_sticky_q  <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         c_q         <= c_d;
         v_q         <= v_d;
         z_q         <= z_d;
         n_q         <= n_d;
         out_valid_q <= out_valid_d;
         v_sticky_q  <= v_sticky_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign c         = c_q;
   assign v         = v_q;
   assign z         = z_q;
   assign n         = n_q;
   assign v_sticky  = v_sticky_q;

endmodule

// File: tb/tb_add_sub_accumulator.sv
// tb_add_sub_accumulator: table vectors, directed multi-cycle sequences and
// random traffic checked against an arithmetic reference model.
module tb_add_sub_accumulator;

   localparam int W    = 8;
   localparam int MAXP = (1 << (W - 1)) - 1;
   localparam int MINN = -(1 << (W - 1));

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [1:0]   op = '0;
   logic         sat = 1'b0;
   logic         clr = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         c, v, z, n, v_sticky;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [W-1:0] m_acc = '0;
   logic         m_sticky = 1'b0;
   logic         m_ov = 1'b0;
   logic [W-1:0] m_sum = '0;
   logic         m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, m_n = 1'b0;

   add_sub_accumulator #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .sat(sat), .clr(clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c(c), .v(v), .z(z), .n(n), .v_sticky(v_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sat;
      logic [W-1:0] e_sum;
      logic         e_c, e_v, e_z, e_n;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Result from plain signed/unsigned integer arithmetic: {sum, c, v, z, n}
   function automatic logic [W+3:0] ref_op(input logic [1:0] o, input logic [W-1:0] ra,
                                           input logic [W-1:0] rb, input logic [W-1:0] accv,
                                           input logic s);
      logic [W-1:0] xv, yv, rs;
      int ux, uy, sx, sy, sr;
      logic cc, vv;
      xv = o[1] ? accv : ra;
      yv = o[1] ? ra : rb;
      ux = int'(xv);
      uy = int'(yv);
      sx = int'($signed(xv));
      sy = int'($signed(yv));
      if (o[0]) begin
         sr = sx - sy;
         cc = (ux >= uy);
      end else begin
         sr = sx + sy;
         cc = ((ux + uy) >= (1 << W));
      end
      vv = (sr > MAXP) || (sr < MINN);
      if (vv && s) rs = (sr > 0) ? W'(MAXP) : W'(MINN);
      else         rs = W'(sr);
      return {rs, cc, vv, (rs == '0), rs[W-1]};
   endfunction

   task automatic model_reset();
      m_acc = '0; m_sticky = 1'b0; m_ov = 1'b0;
      m_sum = '0; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0; m_n = 1'b0;
   endtask

   // One clock with current inputs: check in_ready, step model, compare outputs.
   task automatic cycle();
      logic         acc_ok;
      logic [W-1:0] accv;
      #1;
      chk("in_ready", in_ready, (!m_ov || out_ready));
      acc_ok = in_valid && (!m_ov || out_ready);
      accv   = clr ? '0 : m_acc;
      if (clr) m_sticky = 1'b0;
      if (acc_ok) begin
         {m_sum, m_c, m_v, m_z, m_n} = ref_op(op, a, b, accv, sat);
         m_sticky = m_sticky | m_v;
         m_acc    = op[1] ? m_sum : accv;
         m_ov     = 1'b1;
      end else begin
         m_acc = accv;
         if (out_ready) m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, m_ov);
      chk("sum", sum, m_sum);
      chk("flags_cvzn", {c, v, z, n}, {m_c, m_v, m_z, m_n});
      chk("v_sticky", v_sticky, m_sticky);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_sum"}, sum, 0);
      chk({tag, "_flags"}, {c, v, z, n, v_sticky}, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      vec_t tbl[7];
      tbl[0] = '{2'b00, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{2'b00, 8'h7F, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{2'b00, 8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{2'b01, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{2'b01, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{2'b01, 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset asserted from time zero
      #2;
      check_all_zero("rst_init");
      #10;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;

      // Table vectors, plain operand ops
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; out_ready = 1'b1; clr = 1'b0;
         op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; sat = tbl[i].sat;
         cycle();
         chk($sformatf("tbl%0d_sum", i), sum, tbl[i].e_sum);
         chk($sformatf("tbl%0d_cvzn", i), {c, v, z, n},
             {tbl[i].e_c, tbl[i].e_v, tbl[i].e_z, tbl[i].e_n});
      end
      chk("tbl_sticky", v_sticky, 1);
      sat = 1'b0;

      // Accumulator sequence: clear, three adds, subtract, clear with add
      in_valid = 1'b0; clr = 1'b1;
      cycle();
      chk("clr_sticky", v_sticky, 0);
      clr = 1'b0; in_valid = 1'b1; op = 2'b10; a = 8'h10;
      for (int i = 1; i <= 3; i++) begin
         cycle();
         chk($sformatf("acc_add%0d", i), sum, 8'h10 * i);
      end
      op = 2'b11; a = 8'h40;
      cycle();
      chk("acc_sub", {sum, n}, {8'hF0, 1'b1});
      op = 2'b10; a = 8'h05; clr = 1'b1;
      cycle();
      chk("clr_with_add", sum, 8'h05);
      clr = 1'b0; a = 8'h00;
      cycle();
      chk("acc_after_clr", sum, 8'h05);

      // Backpressure: result held, in_ready low, pending beat taken on release
      op = 2'b00; a = 8'h01; b = 8'h02;
      cycle();
      chk("bp_first", sum, 8'h03);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 8'h10 + 8'(i); b = 8'(i);
         cycle();
         chk("bp_hold_sum", sum, 8'h03);
         chk("bp_in_ready", in_ready, 0);
      end
      a = 8'h05; b = 8'h06; out_ready = 1'b1;
      cycle();
      chk("bp_release", sum, 8'h0B);
      in_valid = 1'b0;
      cycle();

      // Asynchronous reset mid-stream with a held result and acc=0x30
      clr = 1'b1;
      cycle();
      clr = 1'b0; in_valid = 1'b1; op = 2'b10; a = 8'h10;
      for (int i = 0; i < 3; i++) cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      cycle();
      chk("pre_rst_hold", {out_valid, sum}, {1'b1, 8'h30});
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_async");
      model_reset();
      #2;
      rst_n = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1; op = 2'b10; a = 8'h00;
      cycle();
      chk("post_rst_acc", {sum, z}, {8'h00, 1'b1});

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         op        = 2'($urandom_range(0, 3));
         a         = 8'($urandom);
         b         = 8'($urandom);
         sat       = 1'($urandom_range(0, 1));
         clr       = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
